// File: rtl/regfile_hilo_pkg.sv
// Shared constants for the register file: write-back bus layout, widths and reset level.
// Consumed by regfile_hilo and regfile_bypass_mux.
package regfile_hilo_pkg;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 5;
    localparam int WB_TO_RF_WD = 104;

    // Field positions inside wb_to_rf_bus (MSB to LSB).
    localparam int HI_WE_BIT     = 103;
    localparam int LO_WE_BIT     = 102;
    localparam int HI_WDATA_LSB  = 70;
    localparam int LO_WDATA_LSB  = 38;
    localparam int RF_WE_BIT     = 37;
    localparam int RF_WADDR_LSB  = 32;
    localparam int RF_WDATA_LSB  = 0;

    localparam logic [DATA_W-1:0] ZERO_WORD  = '0;
    localparam logic              RST_ACTIVE = 1'b0;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Write-through forwarding mux for one read port; compiled only when REGFILE_WR_BYPASS_EN
// is defined, so the default build carries no unused module.
`ifdef REGFILE_WR_BYPASS_EN
module regfile_bypass_mux
    import regfile_hilo_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic [DW-1:0] stored,
    input  logic [AW-1:0] raddr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic hit;

    // Address 0 is never a real write target, so it can never forward.
    assign hit   = we && (waddr != '0) && (raddr == waddr);
    assign rdata = hit ? wdata : stored;

endmodule
`endif

// File: rtl/regfile_hilo.sv
// GPR/HI/LO architectural state: commits the packed WB bus and serves combinational ID reads.
// Optional same-cycle write-through forwarding under REGFILE_WR_BYPASS_EN.
module regfile_hilo
    import regfile_hilo_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int AW    = ADDR_W,
    parameter int BUS_W = WB_TO_RF_WD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] wb_to_rf_bus,
    input  logic [AW-1:0]    raddr1,
    output logic [DW-1:0]    rdata1,
    input  logic [AW-1:0]    raddr2,
    output logic [DW-1:0]    rdata2,
    output logic [DW-1:0]    hi_rdata,
    output logic [DW-1:0]    lo_rdata,
    output logic [DW-1:0]    rf_wr_cnt
);

    localparam int NUM_REGS = 2 ** AW;

    logic          hi_we;
    logic          lo_we;
    logic [DW-1:0] hi_wdata;
    logic [DW-1:0] lo_wdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    assign hi_we    = wb_to_rf_bus[HI_WE_BIT];
    assign lo_we    = wb_to_rf_bus[LO_WE_BIT];
    assign hi_wdata = wb_to_rf_bus[HI_WDATA_LSB +: DW];
    assign lo_wdata = wb_to_rf_bus[LO_WDATA_LSB +: DW];
    assign rf_we    = wb_to_rf_bus[RF_WE_BIT];
    assign rf_waddr = wb_to_rf_bus[RF_WADDR_LSB +: AW];
    assign rf_wdata = wb_to_rf_bus[RF_WDATA_LSB +: DW];

    // $0 has no storage; entries start at 1.
    logic [DW-1:0] gpr [1:NUM_REGS-1];
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic [DW-1:0] wr_cnt;
    logic          gpr_commit;

    assign gpr_commit = rf_we && (rf_waddr != '0);

    // NOTE: the GPR array is a bank of flops, not a RAM macro, so clearing it in reset is legal;
    // the loop unrolls into per-entry synchronous clears.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                gpr[i] <= ZERO_WORD;
            end
            hi     <= ZERO_WORD;
            lo     <= ZERO_WORD;
            wr_cnt <= ZERO_WORD;
        end else begin
            if (gpr_commit) begin
                gpr[rf_waddr] <= rf_wdata;
                wr_cnt        <= wr_cnt + 1'b1;
            end
            if (hi_we) hi <= hi_wdata;
            if (lo_we) lo <= lo_wdata;
        end
    end

    logic [DW-1:0] stored1;
    logic [DW-1:0] stored2;

    assign stored1   = (raddr1 == '0) ? ZERO_WORD : gpr[raddr1];
    assign stored2   = (raddr2 == '0) ? ZERO_WORD : gpr[raddr2];
    assign rf_wr_cnt = wr_cnt;

`ifdef REGFILE_WR_BYPASS_EN
    logic byp_ok;

    // Forwarding would show data that reset is about to discard.
    assign byp_ok = (rst != RST_ACTIVE);

    regfile_bypass_mux #(.DW(DW), .AW(AW)) u_byp_rd1 (
        .stored (stored1),
        .raddr  (raddr1),
        .we     (rf_we && byp_ok),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .rdata  (rdata1)
    );

    regfile_bypass_mux #(.DW(DW), .AW(AW)) u_byp_rd2 (
        .stored (stored2),
        .raddr  (raddr2),
        .we     (rf_we && byp_ok),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .rdata  (rdata2)
    );

    // HI/LO are single registers: tie both addresses to the same nonzero value so only we matters.
    regfile_bypass_mux #(.DW(DW), .AW(AW)) u_byp_hi (
        .stored (hi),
        .raddr  ({AW{1'b1}}),
        .we     (hi_we && byp_ok),
        .waddr  ({AW{1'b1}}),
        .wdata  (hi_wdata),
        .rdata  (hi_rdata)
    );

    regfile_bypass_mux #(.DW(DW), .AW(AW)) u_byp_lo (
        .stored (lo),
        .raddr  ({AW{1'b1}}),
        .we     (lo_we && byp_ok),
        .waddr  ({AW{1'b1}}),
        .wdata  (lo_wdata),
        .rdata  (lo_rdata)
    );
`else
    assign rdata1   = stored1;
    assign rdata2   = stored2;
    assign hi_rdata = hi;
    assign lo_rdata = lo;
`endif

endmodule

// File: tb/tb_regfile_hilo.sv
// Scoreboard bench for regfile_hilo: directed vectors push expected outputs, a negedge monitor
// pops and compares them. Expectations follow REGFILE_WR_BYPASS_EN when it is defined.
module tb_regfile_hilo;

    typedef enum logic [2:0] {O_RD1, O_RD2, O_HI, O_LO, O_CNT} osel_t;

    typedef struct {
        string       name;
        osel_t       sel;
        logic [31:0] val;
    } exp_t;

`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [103:0] wb_to_rf_bus;
    logic [4:0]   raddr1;
    logic [4:0]   raddr2;
    logic [31:0]  rdata1;
    logic [31:0]  rdata2;
    logic [31:0]  hi_rdata;
    logic [31:0]  lo_rdata;
    logic [31:0]  rf_wr_cnt;

    exp_t sb[$];
    bit   obs_valid = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;

    regfile_hilo dut (
        .clk          (clk),
        .rst          (rst),
        .wb_to_rf_bus (wb_to_rf_bus),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .hi_rdata     (hi_rdata),
        .lo_rdata     (lo_rdata),
        .rf_wr_cnt    (rf_wr_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [103:0] mk_bus(input logic hwe, input logic lwe,
                                            input logic [31:0] hd, input logic [31:0] ld,
                                            input logic rwe, input logic [4:0] wa,
                                            input logic [31:0] wd);
        return {hwe, lwe, hd, ld, rwe, wa, wd};
    endfunction

    function automatic logic [31:0] pick(input osel_t s);
        case (s)
            O_RD1:   return rdata1;
            O_RD2:   return rdata2;
            O_HI:    return hi_rdata;
            O_LO:    return lo_rdata;
            default: return rf_wr_cnt;
        endcase
    endfunction

    task automatic expect_out(input string name, input osel_t sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [103:0] bus, input logic [4:0] a1, input logic [4:0] a2);
        wb_to_rf_bus = bus;
        raddr1       = a1;
        raddr2       = a2;
    endtask

    // Exposes the current cycle's outputs to the monitor, then advances past the next edge.
    task automatic tick();
        obs_valid = 1'b1;
        @(posedge clk);
        #1;
        obs_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (obs_valid) begin
            while (sb.size() > 0) begin
                exp_t    e;
                logic [31:0] got;
                e   = sb.pop_front();
                got = pick(e.sel);
                n_checks++;
                if (got !== e.val) begin
                    n_errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        drive(mk_bus(1'b1, 1'b1, 32'h55, 32'h66, 1'b1, 5'd5, 32'h1234), 5'd5, 5'd5);
        @(posedge clk);
        #1;
        // Second reset cycle: stored state is already clear and bypass must stay quiet.
        expect_out("rst_hold_rd1", O_RD1, 32'h0);
        expect_out("rst_hold_hi",  O_HI,  32'h0);
        tick();

        rst = 1'b1;
        drive('0, 5'd5, 5'd5);
        expect_out("rst_rd1_r5", O_RD1, 32'h0);
        expect_out("rst_rd2_r5", O_RD2, 32'h0);
        expect_out("rst_hi",     O_HI,  32'h0);
        expect_out("rst_lo",     O_LO,  32'h0);
        expect_out("rst_cnt",    O_CNT, 32'h0);
        tick();

        drive(mk_bus(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 32'hDEADBEEF), 5'd7, 5'd0);
        expect_out("wr7_same_cycle", O_RD1, BYP ? 32'hDEADBEEF : 32'h0);
        tick();
        drive('0, 5'd7, 5'd7);
        expect_out("rd7_port1", O_RD1, 32'hDEADBEEF);
        expect_out("rd7_port2", O_RD2, 32'hDEADBEEF);
        expect_out("cnt_after_wr7", O_CNT, 32'd1);
        tick();

        drive(mk_bus(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF), 5'd0, 5'd0);
        expect_out("r0_write_same", O_RD1, 32'h0);
        tick();
        drive('0, 5'd0, 5'd7);
        expect_out("r0_after_write", O_RD1, 32'h0);
        expect_out("cnt_r0_unchanged", O_CNT, 32'd1);
        tick();

        drive(mk_bus(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 32'h11), 5'd3, 5'd7);
        tick();
        drive(mk_bus(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 32'hA5A5A5A5), 5'd3, 5'd7);
        expect_out("raw_r3_same", O_RD1, BYP ? 32'hA5A5A5A5 : 32'h11);
        expect_out("raw_r7_other", O_RD2, 32'hDEADBEEF);
        expect_out("cnt_before_r3b", O_CNT, 32'd2);
        tick();
        drive('0, 5'd3, 5'd3);
        expect_out("raw_r3_next", O_RD1, 32'hA5A5A5A5);
        expect_out("cnt_after_r3b", O_CNT, 32'd3);
        tick();

        drive(mk_bus(1'b1, 1'b0, 32'h0F, 32'h99, 1'b1, 5'd31, 32'h42), 5'd31, 5'd3);
        expect_out("hilo_hi_same", O_HI, BYP ? 32'h0F : 32'h0);
        expect_out("hilo_lo_same", O_LO, 32'h0);
        tick();
        drive('0, 5'd31, 5'd3);
        expect_out("hilo_hi_next", O_HI, 32'h0F);
        expect_out("hilo_lo_next", O_LO, 32'h0);
        expect_out("hilo_r31",     O_RD1, 32'h42);
        expect_out("hilo_cnt",     O_CNT, 32'd4);
        tick();

        drive(mk_bus(1'b0, 1'b1, 32'hBAD, 32'h12345678, 1'b0, 5'd9, 32'hBAD), 5'd9, 5'd31);
        tick();
        drive('0, 5'd9, 5'd31);
        expect_out("lo_only_lo", O_LO, 32'h12345678);
        expect_out("lo_only_hi", O_HI, 32'h0F);
        expect_out("lo_only_r9", O_RD1, 32'h0);
        expect_out("lo_only_cnt", O_CNT, 32'd4);
        tick();

        force dut.wr_cnt = 32'hFFFFFFFF;
        #1;
        release dut.wr_cnt;
        drive(mk_bus(1'b0, 1'b0, '0, '0, 1'b1, 5'd1, 32'hCAFE), 5'd1, 5'd0);
        expect_out("cnt_preload", O_CNT, 32'hFFFFFFFF);
        tick();
        drive('0, 5'd1, 5'd0);
        expect_out("cnt_wrap", O_CNT, 32'h0);
        expect_out("wrap_r1",  O_RD1, 32'hCAFE);
        tick();

        rst = 1'b0;
        drive(mk_bus(1'b1, 1'b1, 32'h1, 32'h2, 1'b1, 5'd7, 32'h77), 5'd7, 5'd31);
        expect_out("midrst_r7_stored", O_RD1, 32'hDEADBEEF);
        expect_out("midrst_hi_stored", O_HI,  32'h0F);
        tick();
        rst = 1'b1;
        drive('0, 5'd7, 5'd31);
        expect_out("midrst_r7",  O_RD1, 32'h0);
        expect_out("midrst_r31", O_RD2, 32'h0);
        expect_out("midrst_hi",  O_HI,  32'h0);
        expect_out("midrst_lo",  O_LO,  32'h0);
        expect_out("midrst_cnt", O_CNT, 32'h0);
        tick();

        @(negedge clk);
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
